// File: rtl/filt_pkg.sv
// Shared constants and word flag type for the filter2d output path.
package filt_pkg;

    localparam int PIX_W      = 8;
    localparam int PACK       = 4;
    localparam int IMG_W      = 256;
    localparam int IMG_H      = 256;
    localparam int FIFO_DEPTH = 16;

    // Per-word position markers carried alongside the packed pixels.
    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } word_flags_t;

    localparam int FLAG_W = $bits(word_flags_t);

endpackage

// File: rtl/filt_out_packer_if.sv
// Valid/ready word stream leaving the packer.
interface filt_out_packer_if #(
    parameter int DATA_W = 32
) ();
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_sof;
    logic              m_eol;
    logic              m_eof;

    modport master (output m_valid, m_data, m_sof, m_eol, m_eof, input m_ready);
    modport slave  (input m_valid, m_data, m_sof, m_eol, m_eof, output m_ready);
endinterface

// File: rtl/filt_sync_fifo.sv
// First-word-fall-through synchronous FIFO. Head reads as zero while empty so
// the word port shows all-zero outputs whenever nothing is valid.
module filt_sync_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_cnt;
    logic             w_wr;
    logic             w_rd;

    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign w_wr    = i_push && (!o_full || i_pop);
    assign w_rd    = i_pop && !o_empty;
    assign o_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == (AW+1)'(DEPTH));
    assign o_rdata = o_empty ? '0 : r_mem[r_rptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Storage; contents need no reset because the head is masked while empty.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= i_wdata;
    end

endmodule

// File: rtl/filt_out_packer.sv
// Packs the filter2d pixel stream PACK pixels per word, tags frame/line
// position and queues words for a valid/ready sink. Drops are flagged sticky.
module filt_out_packer #(
    parameter int PIX_W      = filt_pkg::PIX_W,
    parameter int PACK       = filt_pkg::PACK,
    parameter int IMG_W      = filt_pkg::IMG_W,
    parameter int IMG_H      = filt_pkg::IMG_H,
    parameter int FIFO_DEPTH = filt_pkg::FIFO_DEPTH
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      i_strb,
    input  logic [PIX_W-1:0]          i_data,
    filt_out_packer_if.master         m,
    output logic                      o_ovf,
    input  logic                      clr_ovf,
    output logic [7:0]                o_frame_cnt
);
    import filt_pkg::*;

    localparam int DATA_W = PIX_W * PACK;
    localparam int XW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int LW     = (PACK > 1) ? $clog2(PACK) : 1;

    logic [XW-1:0]                r_x;
    logic [YW-1:0]                r_y;
    logic [LW-1:0]                r_lane;
    logic [PACK-2:0][PIX_W-1:0]   r_pack;
    logic                         r_ovf;
    logic [7:0]                   r_frame_cnt;

    logic                         w_x_last;
    logic                         w_y_last;
    logic                         w_lane_last;
    logic                         w_push;
    logic                         w_pop;
    logic                         w_full;
    logic                         w_empty;
    logic                         w_drop;
    word_flags_t                  w_flags;
    word_flags_t                  w_hflags;
    logic [FLAG_W+DATA_W-1:0]     w_wdata;
    logic [FLAG_W+DATA_W-1:0]     w_rdata;

    assign w_x_last    = (r_x == XW'(IMG_W-1));
    assign w_y_last    = (r_y == YW'(IMG_H-1));
    assign w_lane_last = (r_lane == LW'(PACK-1));

    // Word completes on the strobe of the last lane; it goes straight to the FIFO.
    assign w_push = i_strb && w_lane_last;
    assign w_pop  = !w_empty && m.m_ready;
    assign w_drop = w_push && w_full && !w_pop;

    assign w_flags.sof = (r_y == '0) && (r_x == XW'(PACK-1));
    assign w_flags.eol = w_x_last;
    assign w_flags.eof = w_x_last && w_y_last;
    assign w_wdata     = {w_flags, i_data, r_pack};

    filt_sync_fifo #(
        .WIDTH (FLAG_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_hflags    = word_flags_t'(w_rdata[FLAG_W+DATA_W-1:DATA_W]);
    assign m.m_valid   = !w_empty;
    assign m.m_data    = w_rdata[DATA_W-1:0];
    assign m.m_sof     = w_hflags.sof;
    assign m.m_eol     = w_hflags.eol;
    assign m.m_eof     = w_hflags.eof;
    assign o_ovf       = r_ovf;
    assign o_frame_cnt = r_frame_cnt;

    // Pixel position and lane counters; they advance on every strobe, even when the word is dropped.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_x    <= '0;
            r_y    <= '0;
            r_lane <= '0;
        end else if (i_strb) begin
            r_lane <= w_lane_last ? '0 : r_lane + 1'b1;
            if (w_x_last) begin
                r_x <= '0;
                r_y <= w_y_last ? '0 : r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    // Hold the leading lanes until the last pixel of the word arrives.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_pack <= '0;
        end else if (i_strb && !w_lane_last) begin
            r_pack[r_lane] <= i_data;
        end
    end

    // Sticky overflow; a new drop outranks a clear on the same edge.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    // Count frames completed at the input, wrapping at 8 bits.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_frame_cnt <= '0;
        end else if (i_strb && w_x_last && w_y_last) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_filt_out_packer.sv
// Bench for filt_out_packer on a reduced 16x4 image: table vectors, directed
// corner sequences and random traffic, all checked against a queue-based model.
module tb_filt_out_packer;
    localparam int PW    = 8;
    localparam int PK    = 4;
    localparam int W     = 16;
    localparam int H     = 4;
    localparam int DEPTH = 16;

    typedef struct packed {
        logic        sof;
        logic        eol;
        logic        eof;
        logic [31:0] data;
    } wrd_t;

    typedef struct {
        logic        s;
        logic [7:0]  d;
        logic        r;
        logic        ev;
        logic [31:0] edata;
        logic        esof;
        logic        eeol;
    } vec_t;

    logic       clk = 1'b0;
    logic       rstn;
    logic       i_strb;
    logic [7:0] i_data;
    logic       clr_ovf;
    logic       o_ovf;
    logic [7:0] o_frame_cnt;

    filt_out_packer_if #(.DATA_W(PW*PK)) bus ();

    filt_out_packer #(
        .PIX_W(PW), .PACK(PK), .IMG_W(W), .IMG_H(H), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rstn(rstn), .i_strb(i_strb), .i_data(i_data), .m(bus),
        .o_ovf(o_ovf), .clr_ovf(clr_ovf), .o_frame_cnt(o_frame_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: expected FIFO contents and input position.
    wrd_t       q[$];
    wrd_t       outq[$];
    int         pix;
    logic       ovf;
    logic [7:0] fcnt;
    logic [7:0] pk[PK];
    int         n_sof, n_eof;
    int         pcnt;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic model_edge(input logic s, input logic [7:0] d, input logic r,
                              input logic c, input logic rn);
        int x, y;
        logic pop, push, drop;
        wrd_t w;
        if (!rn) begin
            q.delete(); pix = 0; ovf = 1'b0; fcnt = 8'd0;
            return;
        end
        pop  = (q.size() != 0) && r;
        push = 1'b0;
        drop = 1'b0;
        w    = '0;
        if (s) begin
            x = pix % W;
            y = pix / W;
            pk[x % PK] = d;
            if (x % PK == PK-1) begin
                push = 1'b1;
                for (int i = 0; i < PK; i++) w.data[i*8 +: 8] = pk[i];
                w.sof = (y == 0) && (x == PK-1);
                w.eol = (x == W-1);
                w.eof = (x == W-1) && (y == H-1);
            end
            pix++;
            if (pix == W*H) begin
                pix = 0;
                fcnt = fcnt + 8'd1;
            end
        end
        if (pop) void'(q.pop_front());
        if (push) begin
            if (q.size() < DEPTH) q.push_back(w);
            else drop = 1'b1;
        end
        if (drop) ovf = 1'b1;
        else if (c) ovf = 1'b0;
    endtask

    task automatic step(input logic s, input logic [7:0] d, input logic r,
                        input logic c, input logic rn);
        wrd_t e;
        i_strb = s; i_data = d; bus.m_ready = r; clr_ovf = c; rstn = rn;
        #0;
        if (rn && bus.m_valid && r) begin
            outq.push_back({bus.m_sof, bus.m_eol, bus.m_eof, bus.m_data});
            if (bus.m_sof) n_sof++;
            if (bus.m_eof) n_eof++;
        end
        model_edge(s, d, r, c, rn);
        @(posedge clk);
        #1;
        e = (q.size() != 0) ? q[0] : '0;
        chk("m_valid", bus.m_valid, q.size() != 0);
        chk("m_data",  bus.m_data,  e.data);
        chk("m_sof",   bus.m_sof,   e.sof);
        chk("m_eol",   bus.m_eol,   e.eol);
        chk("m_eof",   bus.m_eof,   e.eof);
        chk("o_ovf",   o_ovf,       ovf);
        chk("o_frame_cnt", o_frame_cnt, fcnt);
    endtask

    task automatic px(input logic r, input logic c);
        step(1'b1, pcnt[7:0], r, c, 1'b1);
        pcnt++;
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, r, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        outq.delete(); pcnt = 0; n_sof = 0; n_eof = 0;
    endtask

    function automatic logic [31:0] ramp(input int i);
        logic [7:0] b0, b1, b2, b3;
        b0 = 8'(4*i); b1 = 8'(4*i+1); b2 = 8'(4*i+2); b3 = 8'(4*i+3);
        return {b3, b2, b1, b0};
    endfunction

    vec_t tbl[12];

    initial begin
        i_strb = 1'b0; i_data = '0; bus.m_ready = 1'b0; clr_ovf = 1'b0; rstn = 1'b0;
        pix = 0; ovf = 1'b0; fcnt = 8'd0; n_sof = 0; n_eof = 0; pcnt = 0;
        for (int i = 0; i < PK; i++) pk[i] = 8'h00;

        tbl[0]  = '{1'b1, 8'h00, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
        tbl[1]  = '{1'b1, 8'h01, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
        tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
        tbl[3]  = '{1'b1, 8'h02, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
        tbl[4]  = '{1'b1, 8'h03, 1'b0, 1'b1, 32'h03020100, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 32'h03020100, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0};
        tbl[7]  = '{1'b1, 8'h04, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
        tbl[8]  = '{1'b1, 8'h05, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
        tbl[9]  = '{1'b1, 8'h06, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
        tbl[10] = '{1'b1, 8'h07, 1'b1, 1'b1, 32'h07060504, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 8'h08, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0};

        // Reset state, then the table vectors.
        do_reset();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].s, tbl[i].d, tbl[i].r, 1'b0, 1'b1);
            chk("tbl_valid", bus.m_valid, tbl[i].ev);
            chk("tbl_data",  bus.m_data,  tbl[i].edata);
            chk("tbl_sof",   bus.m_sof,   tbl[i].esof);
            chk("tbl_eol",   bus.m_eol,   tbl[i].eeol);
        end

        // One frame at one strobe every 17 clocks, sink always ready.
        do_reset();
        for (int i = 0; i < W*H; i++) begin
            px(1'b1, 1'b0);
            idle(16, 1'b1);
        end
        chk("t1_words", outq.size(), W*H/PK);
        if (outq.size() == W*H/PK) begin
            chk("t1_first", {outq[0].sof, outq[0].data}, {1'b1, 32'h03020100});
            chk("t1_eol",   {outq[3].eol, outq[3].data}, {1'b1, 32'h0F0E0D0C});
            chk("t1_last",  {outq[15].eof, outq[15].data}, {1'b1, 32'h3F3E3D3C});
        end
        chk("t1_frames", o_frame_cnt, 8'd1);
        chk("t1_ovf", o_ovf, 1'b0);

        // Stalled sink: 16 words held, the 17th dropped, then drained in order.
        do_reset();
        for (int i = 0; i < 100; i++) begin
            px(1'b0, 1'b0);
            if (pcnt == 64) chk("t2_ovf_at_16", o_ovf, 1'b0);
            if (pcnt == 68) chk("t2_ovf_at_17", o_ovf, 1'b1);
        end
        chk("t2_head", bus.m_data, 32'h03020100);
        idle(20, 1'b1);
        chk("t2_drained", outq.size(), DEPTH);
        for (int i = 0; i < DEPTH && i < outq.size(); i++) chk("t2_order", outq[i].data, ramp(i));
        for (int i = 0; i < 60; i++) px(1'b1, 1'b0);

        // Clear without a new overflow, then clear colliding with a drop.
        idle(4, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        chk("t6_clr", o_ovf, 1'b0);
        for (int i = 0; i < 72; i++) px(1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        chk("t6_clr2", o_ovf, 1'b0);
        for (int i = 0; i < 4; i++) px(1'b0, 1'b1);
        chk("t6_set_wins", o_ovf, 1'b1);

        // Full FIFO with push and pop on the same edge.
        do_reset();
        for (int i = 0; i < 64; i++) px(1'b0, 1'b0);
        for (int i = 0; i < 64; i++) px(pcnt % 4 == 3, 1'b0);
        chk("t3_ovf", o_ovf, 1'b0);
        chk("t3_full_valid", bus.m_valid, 1'b1);
        idle(20, 1'b1);
        chk("t3_words", outq.size(), 32);
        for (int i = 0; i < outq.size(); i++) chk("t3_order", outq[i].data, ramp(i));

        // Reset in the middle of a frame.
        do_reset();
        for (int i = 0; i < 130; i++) px(1'b1, 1'b0);
        step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        chk("t4_rst", {bus.m_valid, bus.m_data, bus.m_sof, bus.m_eol, bus.m_eof, o_ovf, o_frame_cnt}, '0);
        outq.delete(); pcnt = 0;
        for (int i = 0; i < 8; i++) px(1'b1, 1'b0);
        idle(3, 1'b1);
        chk("t4_words", outq.size(), 2);
        if (outq.size() > 0) chk("t4_sof", {outq[0].sof, outq[0].data}, {1'b1, 32'h03020100});

        // Continuous frames and frame counter wrap.
        do_reset();
        for (int i = 0; i < 3*W*H; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b1);
        idle(4, 1'b1);
        chk("t5_frames", o_frame_cnt, 8'd3);
        chk("t5_sof", n_sof, 3);
        chk("t5_eof", n_eof, 3);
        for (int i = 0; i < 253*W*H; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b1);
        chk("t5_wrap", o_frame_cnt, 8'd0);

        // Random strobes, stalls and clears.
        do_reset();
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 31) == 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
